// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int PC_WIDTH = 16;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    // One buffered fetch: instruction word plus the PC it came from and PC+4.
    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] inc_pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch entries with push, pop, flush and a live count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // A pop in the flush cycle is still honoured; the flush then clears everything anyway.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues PC to a 1-cycle ROM, queues returned words and hands them to decode.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = fetch_pkg::PC_WIDTH,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] PC,
    input  logic [PC_WIDTH-1:0] inc_PC,
    input  logic                redirect,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                pc_hold,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [31:0]         dec_instr,
    output logic [PC_WIDTH-1:0] dec_pc,
    output logic [PC_WIDTH-1:0] dec_inc_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] meta_pc_q, meta_pc_d;
    logic [PC_WIDTH-1:0] meta_inc_q, meta_inc_d;
    logic [CW-1:0]       count;
    logic [CW:0]         credits_used;
    logic                issue;
    logic                push;
    logic                pop;
    fetch_entry_t        push_entry;
    fetch_entry_t        head;

    // Credits are based on registered state only so dec_ready never reaches pc_hold.
    assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue        = !rst && !redirect && (credits_used < (CW+1)'(DEPTH));
    assign pc_hold      = !issue && !redirect;
    assign imem_addr    = PC;

    always_comb begin
        inflight_d = issue;
        meta_pc_d  = meta_pc_q;
        meta_inc_d = meta_inc_q;
        if (issue) begin
            meta_pc_d  = PC;
            meta_inc_d = inc_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            meta_pc_q  <= RESET_PC;
            meta_inc_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            meta_pc_q  <= meta_pc_d;
            meta_inc_q <= meta_inc_d;
        end
    end

    // A word returning during a redirect belongs to the wrong path and is dropped.
    assign push       = inflight_q && !redirect;
    assign pop        = dec_valid && dec_ready;
    assign push_entry = '{instr: imem_rdata, pc: meta_pc_q, inc_pc: meta_inc_q};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .flush_i    (redirect),
        .head_o     (head),
        .count_o    (count)
    );

    assign dec_valid  = (count != '0);
    assign dec_instr  = head.instr;
    assign dec_pc     = head.pc;
    assign dec_inc_pc = head.inc_pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a program-counter and ROM model around it.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic [15:0] pcReg;
    logic [15:0] incPc;
    logic        redirect;
    logic [15:0] target;
    logic [15:0] imemAddr;
    logic [31:0] imemRdata;
    logic        pcHold;
    logic        decValid;
    logic        decReady;
    logic [31:0] decInstr;
    logic [15:0] decPc;
    logic [15:0] decIncPc;

    int testsRun;
    int testsFailed;

    instr_fetch_queue dut (
        .clk       (clk),
        .rst       (rst),
        .PC        (pcReg),
        .inc_PC    (incPc),
        .redirect  (redirect),
        .imem_addr (imemAddr),
        .imem_rdata(imemRdata),
        .pc_hold   (pcHold),
        .dec_valid (decValid),
        .dec_ready (decReady),
        .dec_instr (decInstr),
        .dec_pc    (decPc),
        .dec_inc_pc(decIncPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [15:0] a);
        return {16'h0000, a} ^ 32'hA5A5_0000;
    endfunction

    // Program counter and synchronous ROM surrounding the fetch stage.
    assign incPc = pcReg + 16'd4;
    always @(posedge clk) begin
        if (rst) begin
            pcReg <= 16'h0000;
        end else if (redirect) begin
            pcReg <= target;
        end else if (!pcHold) begin
            pcReg <= pcReg + 16'd4;
        end
        imemRdata <= romWord(imemAddr);
    end

    // Leaves the caller at the negedge of the first cycle after reset release.
    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        redirect = 1'b0;
        target   = 16'h0000;
        decReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        #1;
        testsRun++;
        if (decValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid: got %b want 0", decValid);
        end
        testsRun++;
        if (decInstr !== 32'h0 || decPc !== 16'h0 || decIncPc !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got instr=%h pc=%h inc=%h want all 0", decInstr, decPc, decIncPc);
        end
        testsRun++;
        if (pcHold !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: got %b want 0", pcHold);
        end
    endtask

    task automatic test_stream();
        logic        expValid;
        logic [15:0] expPc;
        doReset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            decReady = 1'b1;
            #1;
            expValid = (c >= 2);
            expPc    = 16'(4 * (c - 2));
            testsRun++;
            if (decValid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL stream_valid c%0d: got %b want %b", c, decValid, expValid);
            end
            if (expValid) begin
                testsRun++;
                if (decPc !== expPc || decIncPc !== expPc + 16'd4 || decInstr !== romWord(expPc)) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_entry c%0d: got pc=%h inc=%h instr=%h want pc=%h inc=%h instr=%h",
                             c, decPc, decIncPc, decInstr, expPc, expPc + 16'd4, romWord(expPc));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] expPcs [5];
        expPcs = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10};
        doReset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            decReady = 1'b0;
            #1;
            testsRun++;
            if (pcHold !== (c >= 4)) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold c%0d: got %b want %b", c, pcHold, (c >= 4));
            end
        end
        testsRun++;
        if (decValid !== 1'b1 || decPc !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL bp_head_stable: got valid=%b pc=%h want 1/0000", decValid, decPc);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            decReady = 1'b1;
            #1;
            testsRun++;
            if (decValid !== 1'b1 || decPc !== expPcs[k]) begin
                testsFailed++;
                $display("[TB] FAIL bp_drain %0d: got valid=%b pc=%h want 1/%h", k, decValid, decPc, expPcs[k]);
            end
        end
    endtask

    task automatic test_single_pop();
        logic [15:0] expPcs [4];
        expPcs = '{16'h4, 16'h8, 16'hC, 16'h10};
        doReset();
        for (int c = 1; c < 6; c++) @(negedge clk);
        @(negedge clk);
        decReady = 1'b1;
        #1;
        testsRun++;
        if (pcHold !== 1'b1 || decPc !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL sp_full: got hold=%b pc=%h want 1/0000", pcHold, decPc);
        end
        @(negedge clk);
        decReady = 1'b0;
        #1;
        testsRun++;
        if (pcHold !== 1'b0 || decPc !== 16'h4) begin
            testsFailed++;
            $display("[TB] FAIL sp_refill: got hold=%b pc=%h want 0/0004", pcHold, decPc);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            testsRun++;
            if (pcHold !== 1'b1 || decPc !== 16'h4) begin
                testsFailed++;
                $display("[TB] FAIL sp_refull %0d: got hold=%b pc=%h want 1/0004", c, pcHold, decPc);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            decReady = 1'b1;
            #1;
            testsRun++;
            if (decValid !== 1'b1 || decPc !== expPcs[k]) begin
                testsFailed++;
                $display("[TB] FAIL sp_drain %0d: got valid=%b pc=%h want 1/%h", k, decValid, decPc, expPcs[k]);
            end
        end
    endtask

    task automatic test_redirect();
        logic [15:0] expPcs [3];
        expPcs = '{16'h40, 16'h44, 16'h48};
        doReset();
        for (int c = 1; c < 4; c++) @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        target   = 16'h0040;
        #1;
        testsRun++;
        if (pcHold !== 1'b0 || pcReg !== 16'h0010 || decPc !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL rd_setup: got hold=%b pc=%h head=%h want 0/0010/0000", pcHold, pcReg, decPc);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            testsRun++;
            if (decValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rd_bubble %0d: got valid=%b want 0", c, decValid);
            end
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (decValid !== 1'b1 || decPc !== 16'h40 || decIncPc !== 16'h44) begin
            testsFailed++;
            $display("[TB] FAIL rd_target: got valid=%b pc=%h inc=%h want 1/0040/0044", decValid, decPc, decIncPc);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            decReady = 1'b1;
            #1;
            testsRun++;
            if (decValid !== 1'b1 || decPc !== expPcs[k]) begin
                testsFailed++;
                $display("[TB] FAIL rd_follow %0d: got valid=%b pc=%h want 1/%h", k, decValid, decPc, expPcs[k]);
            end
        end
    endtask

    task automatic test_redirect_pop();
        doReset();
        decReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        target   = 16'h0080;
        #1;
        testsRun++;
        if (decValid !== 1'b1 || decPc !== 16'h4) begin
            testsFailed++;
            $display("[TB] FAIL rp_pop: got valid=%b pc=%h want 1/0004", decValid, decPc);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            testsRun++;
            if (decValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rp_bubble %0d: got valid=%b want 0", c, decValid);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            testsRun++;
            if (decValid !== 1'b1 || decPc !== 16'(16'h80 + 4 * k)) begin
                testsFailed++;
                $display("[TB] FAIL rp_target %0d: got valid=%b pc=%h want 1/%h", k, decValid, decPc, 16'(16'h80 + 4 * k));
            end
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        testsRun++;
        if (decValid !== 1'b1 || decPc !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL mr_before: got valid=%b pc=%h want 1/0000", decValid, decPc);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        testsRun++;
        if (decValid !== 1'b0 || decPc !== 16'h0 || decIncPc !== 16'h0 || decInstr !== 32'h0 || pcHold !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mr_cleared: got valid=%b pc=%h inc=%h instr=%h hold=%b want 0/0/0/0/0",
                     decValid, decPc, decIncPc, decInstr, pcHold);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (decValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mr_bubble: got valid=%b want 0", decValid);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (decValid !== 1'b1 || decPc !== 16'h0 || decIncPc !== 16'h4 || decInstr !== romWord(16'h0)) begin
            testsFailed++;
            $display("[TB] FAIL mr_restart: got valid=%b pc=%h inc=%h instr=%h want 1/0000/0004/%h",
                     decValid, decPc, decIncPc, decInstr, romWord(16'h0));
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        target      = 16'h0000;
        decReady    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_single_pop();
        test_redirect();
        test_redirect_pop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
